// File: rtl/risc16_cycle_sequencer.sv
// Multi-cycle FETCH/EXEC sequencer for the RiSC-16 core: generates the IR/PC load strobes
// and the committed RF/DMEM write enables, and counts retired instructions.
module risc16_cycle_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             hold,
    input  logic [1:0]       wait_cycle,
    input  logic             werf,
    input  logic             wedmem,
    output logic             ir_load,
    output logic             pc_load,
    output logic             rf_we_n,
    output logic             dmem_we_n,
    output logic             busy,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            retire_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (commit)
                retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    // hold suppresses every transition and strobe; the state only shows through busy/phase.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        ir_load   = 1'b0;
        pc_load   = 1'b0;
        rf_we_n   = 1'b1;
        dmem_we_n = 1'b1;
        if (!hold) begin
            case (state)
                IDLE: begin
                    if (run)
                        state_nxt = FETCH;
                end
                FETCH: begin
                    ir_load   = 1'b1;
                    state_nxt = EXEC;
                    cnt_nxt   = 2'd0;
                end
                EXEC: begin
                    // >= so a wait_cycle lowered below cnt mid-instruction still commits.
                    if (cnt >= wait_cycle) begin
                        commit    = 1'b1;
                        pc_load   = 1'b1;
                        rf_we_n   = werf;
                        dmem_we_n = wedmem;
                        state_nxt = run ? FETCH : IDLE;
                    end else begin
                        cnt_nxt = cnt + 2'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign phase = state;

endmodule

// File: tb/tb_risc16_cycle_sequencer.sv
// Bench for risc16_cycle_sequencer: per-cycle expected output words queued by the drivers
// and compared by a negedge monitor, plus direct checks for reset and counter wrap.
module tb_risc16_cycle_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, hold, werf, wedmem;
  logic [1:0]  wait_cycle;
  logic        ir_load, pc_load, rf_we_n, dmem_we_n, busy;
  logic [1:0]  phase;
  logic [15:0] retire_cnt;

  logic        ir_load4, pc_load4, rf_we_n4, dmem_we_n4, busy4;
  logic [1:0]  phase4;
  logic [3:0]  retire_cnt4;

  int          checks = 0;
  int          failures = 0;
  logic        mon_en = 1'b0;
  logic [15:0] exp_retire = 16'd0;
  logic [6:0]  exp_q[$];

  typedef struct {
    logic [1:0] wc;
    logic       werf;
    logic       wedmem;
    int         exp_clocks;
    logic       exp_rf_n;
    logic       exp_dm_n;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  risc16_cycle_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .hold(hold), .wait_cycle(wait_cycle),
    .werf(werf), .wedmem(wedmem), .ir_load(ir_load), .pc_load(pc_load),
    .rf_we_n(rf_we_n), .dmem_we_n(dmem_we_n), .busy(busy), .phase(phase),
    .retire_cnt(retire_cnt)
  );

  risc16_cycle_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .run(run), .hold(hold), .wait_cycle(wait_cycle),
    .werf(werf), .wedmem(wedmem), .ir_load(ir_load4), .pc_load(pc_load4),
    .rf_we_n(rf_we_n4), .dmem_we_n(dmem_we_n4), .busy(busy4), .phase(phase4),
    .retire_cnt(retire_cnt4)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // {ir_load, pc_load, rf_we_n, dmem_we_n, busy, phase}
  function automatic logic [6:0] w(input logic ir, input logic pc, input logic rf,
                                   input logic dm, input logic bsy, input logic [1:0] ph);
    return {ir, pc, rf, dm, bsy, ph};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_cycle", 32'(1), 32'(0));
      end else begin
        logic [6:0] e;
        e = exp_q.pop_front();
        chk("cycle", 32'({ir_load, pc_load, rf_we_n, dmem_we_n, busy, phase}), 32'(e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction starting from a FETCH cycle; drop_run clears run once in EXEC.
  task automatic do_instr(input vec_t v, input logic drop_run);
    wait_cycle = v.wc;
    werf       = v.werf;
    wedmem     = v.wedmem;
    exp_q.push_back(w(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1));
    for (int i = 0; i < v.exp_clocks - 2; i++)
      exp_q.push_back(w(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2));
    exp_q.push_back(w(1'b0, 1'b1, v.exp_rf_n, v.exp_dm_n, 1'b1, 2'd2));
    step();
    if (drop_run) run = 1'b0;
    repeat (v.exp_clocks - 1) step();
    exp_retire = exp_retire + 16'd1;
    chk("retire_cnt", 32'(retire_cnt), 32'(exp_retire));
  endtask

  task automatic idle_cycle();
    exp_q.push_back(w(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0));
    step();
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{2'd0, 1'b0, 1'b1, 2, 1'b0, 1'b1};
    vecs[1] = '{2'd2, 1'b1, 1'b0, 4, 1'b1, 1'b0};
    vecs[2] = '{2'd1, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    vecs[3] = '{2'd3, 1'b1, 1'b1, 5, 1'b1, 1'b1};
    vecs[4] = '{2'd0, 1'b1, 1'b0, 2, 1'b1, 1'b0};
    vecs[5] = '{2'd1, 1'b1, 1'b1, 3, 1'b1, 1'b1};
    for (int k = 6; k < NV; k++) begin
      vecs[k].wc         = 2'($urandom_range(0, 3));
      vecs[k].werf       = 1'($urandom_range(0, 1));
      vecs[k].wedmem     = 1'($urandom_range(0, 1));
      vecs[k].exp_clocks = 2 + int'(vecs[k].wc);
      vecs[k].exp_rf_n   = vecs[k].werf;
      vecs[k].exp_dm_n   = vecs[k].wedmem;
    end

    // reset
    rst = 1'b1; run = 1'b0; hold = 1'b0; wait_cycle = 2'd0; werf = 1'b0; wedmem = 1'b0;
    repeat (2) step();
    chk("rst_ir_load", 32'(ir_load), 32'(0));
    chk("rst_pc_load", 32'(pc_load), 32'(0));
    chk("rst_rf_we_n", 32'(rf_we_n), 32'(1));
    chk("rst_dmem_we_n", 32'(dmem_we_n), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_phase", 32'(phase), 32'(0));
    chk("rst_retire", 32'(retire_cnt), 32'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    // table-driven back-to-back instructions; run drops during the last one
    run = 1'b1;
    idle_cycle();
    for (int k = 0; k < NV; k++) do_instr(vecs[k], k == NV - 1);
    repeat (3) idle_cycle();

    // hold for 3 clocks during EXEC of a wait_cycle=1 op: 6 clocks total
    run = 1'b1;
    idle_cycle();
    wait_cycle = 2'd1; werf = 1'b0; wedmem = 1'b0;
    exp_q.push_back(w(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1));
    step();
    exp_q.push_back(w(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2));
    step();
    hold = 1'b1;
    repeat (3) begin
      exp_q.push_back(w(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2));
      step();
    end
    hold = 1'b0; run = 1'b0;
    exp_q.push_back(w(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2));
    step();
    exp_retire = exp_retire + 16'd1;
    chk("hold_retire", 32'(retire_cnt), 32'(exp_retire));
    idle_cycle();

    // wait_cycle lowered below cnt mid-EXEC commits on the next EXEC cycle
    run = 1'b1;
    idle_cycle();
    wait_cycle = 2'd3; werf = 1'b0; wedmem = 1'b1;
    exp_q.push_back(w(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1));
    step();
    repeat (2) begin
      exp_q.push_back(w(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2));
      step();
    end
    wait_cycle = 2'd1; run = 1'b0;
    exp_q.push_back(w(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2));
    step();
    exp_retire = exp_retire + 16'd1;
    chk("ge_retire", 32'(retire_cnt), 32'(exp_retire));
    idle_cycle();

    // async reset in the middle of a wait_cycle=2 op abandons it
    mon_en = 1'b0;
    run = 1'b1; wait_cycle = 2'd2; werf = 1'b0; wedmem = 1'b0;
    repeat (3) step();
    chk("pre_rst_phase", 32'(phase), 32'(2));
    #2 rst = 1'b1;
    #1;
    chk("midrst_ir_load", 32'(ir_load), 32'(0));
    chk("midrst_pc_load", 32'(pc_load), 32'(0));
    chk("midrst_rf_we_n", 32'(rf_we_n), 32'(1));
    chk("midrst_dmem_we_n", 32'(dmem_we_n), 32'(1));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_phase", 32'(phase), 32'(0));
    chk("midrst_retire", 32'(retire_cnt), 32'(0));
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_rf_we_n", 32'(rf_we_n), 32'(1));
      chk("rst_hold_phase", 32'(phase), 32'(0));
    end
    step();
    rst = 1'b0; run = 1'b0;
    exp_retire = 16'd0;
    mon_en = 1'b1;

    // counter wrap, seen on the 4-bit instance after 16 commits (F + 1 -> 0)
    run = 1'b1;
    idle_cycle();
    v = '{2'd0, 1'b1, 1'b1, 2, 1'b1, 1'b1};
    for (int i = 0; i < 16; i++) begin
      do_instr(v, i == 15);
      if (i == 14) chk("wrap_pre", 32'(retire_cnt4), 32'(4'hF));
    end
    chk("wrap_post", 32'(retire_cnt4), 32'(4'h0));
    idle_cycle();

    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
